// File: rtl/fpadd_pkg.sv
// ----------------------------------------------------------------------------
// fpadd_pkg
// Shared definitions for the floating-point adder datapath stages.
//   align_state_e   : mantissa alignment FSM states (IDLE, SHIFT, DONE)
//   GRS_W           : width of the guard/round/sticky extension
//   sticky_collapse : OR-reduces a mantissa into a single sticky bit
// ----------------------------------------------------------------------------
package fpadd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } align_state_e;

   localparam int unsigned GRS_W = 3;

   // Widest mantissa the sticky helper accepts; narrower callers zero-extend.
   localparam int unsigned STICKY_MAX_W = 64;

   function automatic logic sticky_collapse(input logic [STICKY_MAX_W-1:0] mant);
      return |mant;
   endfunction

endpackage

// File: rtl/align_step.sv
// ----------------------------------------------------------------------------
// align_step
// Combinational one-bit right shift of a mantissa carrying guard/round/sticky
// bits. The bit leaving position 1 is ORed into the sticky bit so that no
// shifted-out one is ever lost.
//   din_i  [W-1:0] : vector before the shift
//   dout_o [W-1:0] : vector after the shift
// ----------------------------------------------------------------------------
module align_step #(
   parameter int unsigned W = 27
) (
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o
);

   assign dout_o = {1'b0, din_i[W-1:2], din_i[1] | din_i[0]};

endmodule

// File: rtl/mant_align.sv
// ----------------------------------------------------------------------------
// mant_align
// Mantissa alignment stage of the floating-point adder. Routes the
// larger-exponent mantissa through unchanged and right-shifts the
// smaller-exponent mantissa by ExpDiff, one bit per cycle, keeping
// guard/round/sticky bits. Valid/ready handshake on both sides.
//
// Ports:
//   Clock, Reset        : clock, asynchronous active-high reset
//   InValid / InReady   : upstream handshake (InReady high only in IDLE)
//   ExpSet              : 1 -> A is the big operand, 0 -> B is
//   ExpDiff  [tN-1:0]   : unsigned exponent difference
//   MantA/B  [MW-1:0]   : operand mantissas
//   OutValid / OutReady : downstream handshake
//   BigMant  [MW-1:0]   : larger-exponent mantissa
//   SmallMant[MW+2:0]   : aligned small mantissa, [2:0] = guard/round/sticky
//   Swapped             : registered !ExpSet
//
// Build option: ALIGN_EARLY_OUT_EN -- differences of MW+2 or more collapse
// straight into the sticky bit at accept instead of iterating.
// ----------------------------------------------------------------------------
module mant_align
   import fpadd_pkg::*;
#(
   parameter int unsigned tN = 8,
   parameter int unsigned MW = 24
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic             ExpSet,
   input  logic [tN-1:0]    ExpDiff,
   input  logic [MW-1:0]    MantA,
   input  logic [MW-1:0]    MantB,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [MW-1:0]    BigMant,
   output logic [MW+2:0]    SmallMant,
   output logic             Swapped
);

   localparam int unsigned SW      = MW + GRS_W;
   localparam int unsigned CNT_MAX = MW + 2;
   localparam int unsigned CW      = $clog2(MW + 3);

   align_state_e  state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [MW-1:0] big_q, big_d;
   logic [SW-1:0] small_q, small_d;
   logic          swapped_q, swapped_d;
   logic          out_valid_q;

   logic [SW-1:0] small_step;
   logic [MW-1:0] small_sel;
   logic          exp_sat;
   logic [CW-1:0] count_load;

   align_step #(.W(SW)) u_step (
      .din_i  (small_q),
      .dout_o (small_step)
   );

   assign small_sel  = ExpSet ? MantB : MantA;
   // Any shift of MW+2 or more leaves only the sticky bit, so saturate there.
   assign exp_sat    = (32'(ExpDiff) >= CNT_MAX);
   assign count_load = exp_sat ? CW'(CNT_MAX) : CW'(ExpDiff);

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      big_d     = big_q;
      small_d   = small_q;
      swapped_d = swapped_q;

      case (state_q)
         IDLE: begin
            if (InValid) begin
               big_d     = ExpSet ? MantA : MantB;
               small_d   = {small_sel, {GRS_W{1'b0}}};
               swapped_d = !ExpSet;
               count_d   = count_load;
               state_d   = (count_load != '0) ? SHIFT : DONE;
`ifdef ALIGN_EARLY_OUT_EN
               if (exp_sat) begin
                  small_d = {{(SW-1){1'b0}}, sticky_collapse(STICKY_MAX_W'(small_sel))};
                  count_d = '0;
                  state_d = DONE;
               end
`endif
            end
         end
         SHIFT: begin
            small_d = small_step;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (OutReady) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         big_q       <= '0;
         small_q     <= '0;
         swapped_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         big_q       <= big_d;
         small_q     <= small_d;
         swapped_q   <= swapped_d;
         out_valid_q <= (state_d == DONE);
      end
   end

   assign InReady   = (state_q == IDLE);
   assign OutValid  = out_valid_q;
   assign BigMant   = big_q;
   assign SmallMant = small_q;
   assign Swapped   = swapped_q;

endmodule

// File: doc/mant_align.md
# mant_align

Mantissa alignment stage of the floating-point adder, directly downstream of the exponent ALU. It takes the exponent comparison result (ExpSet, ExpDiff) and both mantissas, routes the larger-exponent mantissa through unchanged, and right-shifts the smaller-exponent mantissa by ExpDiff, one bit per cycle. The shift keeps guard, round and sticky bits for later rounding. It uses a valid/ready handshake on both sides, so the add/normalize stage can stall it.

## Interface
Parameters:
- tN, 8 — exponent width; must match the exponent ALU.
- MW, 24 — mantissa width including the hidden bit.

Ports:
- Clock  in  1  — single clock; all state updates on the rising edge.
- Reset  in  1  — asynchronous, active-high.
- InValid  in  1  — upstream operands valid.
- InReady  out  1  — block can accept; high only in IDLE.
- ExpSet  in  1  — 1: ExpA >= ExpB (A is the big operand); 0: B is the big operand.
- ExpDiff  in  tN  — unsigned exponent magnitude difference.
- MantA, MantB  in  MW  — operand mantissas.
- OutValid  out  1  — aligned result valid.
- OutReady  in  1  — downstream accepts the result.
- BigMant  out  MW  — mantissa of the larger-exponent operand.
- SmallMant  out  MW+3  — aligned small mantissa; bits [MW+2:3] mantissa, [2] guard, [1] round, [0] sticky.
- Swapped  out  1  — equals the registered value of !ExpSet.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - InReady=1.
  - On InValid&&InReady:
    - Big = ExpSet ? MantA : MantB.
    - Small = {(ExpSet ? MantB : MantA), 3'b000}.
    - Count = min(ExpDiff, MW+2).
  - Next state is SHIFT if Count != 0, else DONE.
- **SHIFT**
  - Each cycle: Small = {1'b0, Small[MW+2:2], Small[1]|Small[0]}; Count decrements.
  - Transition to DONE when the shift that brings Count to 0 occurs.
- **DONE**
  - OutValid=1.
  - Outputs hold stable while OutReady=0.
  - On OutReady=1, go to IDLE.
  - There is no same-cycle re-accept.
- Count saturation:
  - Shifting by MW+2 is equivalent to any larger shift: the whole mantissa collapses into the sticky bit.
  - Count is therefore MW+2 wide enough (ceil(log2(MW+3)) bits) and never wraps.
- ExpDiff=0: no shift; SmallMant = {mantissa, 000}.
- InValid and the operand inputs are ignored outside IDLE.
- Reset, asynchronous at any time including mid-SHIFT:
  - state=IDLE; OutValid=0; InReady=1.
  - BigMant=0, SmallMant=0, Swapped=0, Count=0.
  - The in-flight operation is discarded.

## Timing
- Accept edge k → OutValid high from edge k+1+N, where N = min(ExpDiff, MW+2).
- Maximum latency is MW+3 cycles (27 at MW=24).
- Throughput: one operation per N+2 cycles minimum (accept, N shifts, DONE handshake).
- InReady is combinational from state only; there is no combinational path from InValid/OutReady to outputs.
- All outputs are registered.

## Configuration
- ALIGN_EARLY_OUT_EN:
  - **Defined:** at accept, if ExpDiff >= MW+2, Small is loaded directly with {(MW+2){1'b0}, |mantissa} and the state goes straight to DONE (latency 1). Smaller differences shift as normal.
  - **Undefined:** all shifts iterate bit-by-bit.
- Final SmallMant values are identical either way; only latency differs.

## Structure
- Shared package fpadd_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the GRS width constant (3);
  - the sticky-collapse helper function used by early-out.
- One sub-module, align_step: a combinational one-bit right shift with sticky OR on an MW+3 vector, instantiated once in the datapath.

## Test plan
All scenarios use MW=24 unless stated.
- ExpSet=1, ExpDiff=1, MantA=24'h800000, MantB=24'hC00000 → OutValid 2 cycles after accept; BigMant=800000, SmallMant[26:3]=600000, GRS=000, Swapped=0.
- ExpSet=0, ExpDiff=2, MantA=24'h000003, MantB=24'hFFFFFF → BigMant=FFFFFF, SmallMant[26:3]=0, GRS=110, Swapped=1, latency 3.
- ExpDiff=0, MantB=24'hABCDEF, ExpSet=1 → SmallMant={ABCDEF,000} after 1 cycle.
- ExpDiff=200, MantB=24'hFFFFFF, ExpSet=1 → SmallMant=27'h0000001.
  - Latency 27 without ALIGN_EARLY_OUT_EN; latency 1 with it.
- OutReady held 0 for 5 cycles in DONE → OutValid and all outputs stable, InReady=0; one cycle after OutReady=1, InReady=1.
- Reset asserted mid-SHIFT (ExpDiff=10, after 4 shifts) → immediately OutValid=0, InReady=1, SmallMant=0; next operation completes correctly.
